ppt_pulse_engine: RTL

Pulsed-plasma-thruster firing engine on the controller side of the I2C register map. It consumes the configuration fields clk_div, period, width, count and run_ppt, and generates the thruster trigger pulse train. It returns count_done and done, which the register map refreshes into its read-only status locations. All timing is derived from a programmable power-of-two prescaler on the system clock, typically a 32.768 kHz oscillator.

---
 rtl/ppt_pulse_engine.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ppt_pulse_engine.sv
// ppt_pulse_engine
//   Pulsed-plasma-thruster firing engine. Latches clk_div/period/width/count
//   on start, then emits a pulse train on ppt_out timed by a power-of-two
//   prescaler tick (D = 2^(min(clk_div,23)+1) clk cycles per tick).
//
//   Optional feature macro: PPT_WIDTH_LIMIT_EN
//     defined   -> effective width additionally capped at MAX_WIDTH ticks
//     undefined -> MAX_WIDTH has no effect
//
// Ports
//   clk         in   system clock
//   rstn        in   asynchronous active-low reset
//   clk_div     in   [4:0]  prescaler exponent
//   period      in   [15:0] repetition period in ticks (min 2)
//   width       in   [15:0] pulse high time in ticks (clamped to period-1)
//   count       in   [15:0] pulses to fire, 0 = continuous
//   run_ppt     in   level run enable, low aborts/rearms
//   ppt_out     out  registered trigger output (high exactly in FIRE_HI)
//   count_done  out  [15:0] periods completed since last start
//   done        out  programmed count reached
module ppt_pulse_engine #(
    parameter int unsigned MAX_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  clk_div,
    input  logic [15:0] period,
    input  logic [15:0] width,
    input  logic [15:0] count,
    input  logic        run_ppt,
    output logic        ppt_out,
    output logic [15:0] count_done,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, FIRE_HI, FIRE_LO, DONE} state_e;

`ifdef PPT_WIDTH_LIMIT_EN
    localparam logic [15:0] WCAP = (MAX_WIDTH > 32'hFFFF) ? 16'hFFFF : 16'(MAX_WIDTH);
`else
    logic unused_max_width;
    assign unused_max_width = (MAX_WIDTH != 0);
`endif

    function automatic logic [15:0] eff_p(input logic [15:0] per);
        return (per < 16'd2) ? 16'd2 : per;
    endfunction

    function automatic logic [15:0] eff_w(input logic [15:0] per, input logic [15:0] wid);
        logic [15:0] p;
        logic [15:0] w;
        p = eff_p(per);
        w = (wid > p - 16'd1) ? p - 16'd1 : wid;
`ifdef PPT_WIDTH_LIMIT_EN
        if (w > WCAP) w = WCAP;
`endif
        return w;
    endfunction

    state_e      state_q, state_d;
    logic [4:0]  div_q, div_d;
    logic [15:0] period_q, period_d;
    logic [15:0] width_q, width_d;
    logic [15:0] count_q, count_d;
    logic [23:0] presc_q, presc_d;
    logic [15:0] t_q, t_d;
    logic [15:0] cd_q, cd_d;
    logic        done_q, done_d;
    logic        ppt_q, ppt_d;

    logic [4:0]  dexp;
    logic [23:0] presc_max;
    logic        tick;
    logic [15:0] w_run;
    logic [15:0] p_run;

    // Terminal prescaler value D-1: a run of (dexp+1) ones.
    assign dexp      = (div_q > 5'd23) ? 5'd23 : div_q;
    assign presc_max = ~(24'hFF_FFFF << (dexp + 5'd1));
    assign tick      = (presc_q == presc_max);
    assign w_run     = eff_w(period_q, width_q);
    assign p_run     = eff_p(period_q);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        period_d = period_q;
        width_d  = width_q;
        count_d  = count_q;
        presc_d  = presc_q;
        t_d      = t_q;
        cd_d     = cd_q;
        done_d   = done_q;

        case (state_q)
            IDLE: begin
                // A held run_ppt cannot re-fire: DONE only returns here once
                // run_ppt has been seen low, so a level start is safe.
                if (run_ppt) begin
                    div_d    = clk_div;
                    period_d = period;
                    width_d  = width;
                    count_d  = count;
                    presc_d  = '0;
                    t_d      = '0;
                    cd_d     = '0;
                    done_d   = 1'b0;
                    state_d  = (eff_w(period, width) != 16'd0) ? FIRE_HI : FIRE_LO;
                end
            end
            FIRE_HI, FIRE_LO: begin
                if (!run_ppt) begin
                    state_d = IDLE;
                end else begin
                    presc_d = tick ? '0 : presc_q + 24'd1;
                    if (tick) begin
                        t_d = t_q + 16'd1;
                        if (state_q == FIRE_HI && t_q == w_run - 16'd1) begin
                            state_d = FIRE_LO;
                        end else if (state_q == FIRE_LO && t_q == p_run - 16'd1) begin
                            t_d  = '0;
                            cd_d = cd_q + 16'd1;
                            if (count_q != 16'd0 && cd_d == count_q) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = (w_run != 16'd0) ? FIRE_HI : FIRE_LO;
                            end
                        end
                    end
                end
            end
            DONE: begin
                if (!run_ppt) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Output registered from next state so it rises/falls on the same
        // edge as the state transition.
        ppt_d = (state_d == FIRE_HI);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            div_q    <= '0;
            period_q <= '0;
            width_q  <= '0;
            count_q  <= '0;
            presc_q  <= '0;
            t_q      <= '0;
            cd_q     <= '0;
            done_q   <= 1'b0;
            ppt_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            period_q <= period_d;
            width_q  <= width_d;
            count_q  <= count_d;
            presc_q  <= presc_d;
            t_q      <= t_d;
            cd_q     <= cd_d;
            done_q   <= done_d;
            ppt_q    <= ppt_d;
        end
    end

    assign ppt_out    = ppt_q;
    assign count_done = cd_q;
    assign done       = done_q;

endmodule
